// File: rtl/wb_port_buffer.sv
// Two-entry Wishbone pipelined request buffer in front of a banked RAM collision arbiter.
// Define WB_PORT_BUFFER_STATS_EN to add the saturating stall_cnt_o retry counter.
module wb_port_buffer #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic            wb_stall_o,
  output logic            wb_ack_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic            req_valid_o,
  output logic            req_ramsel_o,
  output logic [AW-2:0]   req_adr_o,
  output logic            req_we_o,
  output logic [DW-1:0]   req_dat_o,
  output logic [DW/8-1:0] req_sel_o,
  input  logic            grant_i,
  input  logic [DW-1:0]   ram_rdata_i
`ifdef WB_PORT_BUFFER_STATS_EN
  ,
  output logic [15:0]     stall_cnt_o
`endif
);

  logic [AW-1:0]   adr_q [2];
  logic [AW-1:0]   adr_d [2];
  logic            we_q  [2];
  logic            we_d  [2];
  logic [DW-1:0]   dat_q [2];
  logic [DW-1:0]   dat_d [2];
  logic [DW/8-1:0] sel_q [2];
  logic [DW/8-1:0] sel_d [2];
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            ack_q, ack_d;
  logic            ack_we_q, ack_we_d;
  logic            push, pop;

  assign wb_stall_o   = (count_q == 2'd2);
  assign req_valid_o  = (count_q != 2'd0) && wb_cyc_i;
  assign req_ramsel_o = adr_q[rd_ptr_q][AW-1];
  assign req_adr_o    = adr_q[rd_ptr_q][AW-2:0];
  assign req_we_o     = we_q[rd_ptr_q];
  assign req_dat_o    = dat_q[rd_ptr_q];
  assign req_sel_o    = sel_q[rd_ptr_q];
  // Masking by wb_cyc_i keeps an ack from leaking into a cycle the master abandoned.
  assign wb_ack_o     = ack_q && wb_cyc_i;
  assign wb_dat_o     = (wb_ack_o && !ack_we_q) ? ram_rdata_i : '0;

  assign push = wb_cyc_i && wb_stb_i && !wb_stall_o;
  assign pop  = req_valid_o && grant_i;

  always_comb begin
    adr_d    = adr_q;
    we_d     = we_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ack_d    = pop;
    ack_we_d = ack_we_q;
    if (push) begin
      adr_d[wr_ptr_q] = wb_adr_i;
      we_d[wr_ptr_q]  = wb_we_i;
      dat_d[wr_ptr_q] = wb_dat_i;
      sel_d[wr_ptr_q] = wb_sel_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      ack_we_d = we_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (!wb_cyc_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      ack_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q    <= '{default: '0};
      we_q     <= '{default: '0};
      dat_q    <= '{default: '0};
      sel_q    <= '{default: '0};
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ack_q    <= 1'b0;
      ack_we_q <= 1'b0;
    end else begin
      adr_q    <= adr_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_q    <= ack_d;
      ack_we_q <= ack_we_d;
    end
  end

`ifdef WB_PORT_BUFFER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_valid_o && !grant_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_buffer.sv
// Directed self-checking bench for wb_port_buffer; stall counter scenario runs only with
// WB_PORT_BUFFER_STATS_EN defined.
module tb_wb_port_buffer;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst_n;
  logic            wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_stall_o, wb_ack_o;
  logic [DW-1:0]   wb_dat_o;
  logic            req_valid_o, req_ramsel_o, req_we_o;
  logic [AW-2:0]   req_adr_o;
  logic [DW-1:0]   req_dat_o;
  logic [DW/8-1:0] req_sel_o;
  logic            grant_i;
  logic [DW-1:0]   ram_rdata_i;
`ifdef WB_PORT_BUFFER_STATS_EN
  logic [15:0]     stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  wb_port_buffer #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_we_i      (wb_we_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_sel_i     (wb_sel_i),
    .wb_stall_o   (wb_stall_o),
    .wb_ack_o     (wb_ack_o),
    .wb_dat_o     (wb_dat_o),
    .req_valid_o  (req_valid_o),
    .req_ramsel_o (req_ramsel_o),
    .req_adr_o    (req_adr_o),
    .req_we_o     (req_we_o),
    .req_dat_o    (req_dat_o),
    .req_sel_o    (req_sel_o),
    .grant_i      (grant_i),
    .ram_rdata_i  (ram_rdata_i)
`ifdef WB_PORT_BUFFER_STATS_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; grant_i = 1'b0; ram_rdata_i = 32'h1234_5678;
    step(); step();
    checks++;
    if ({wb_stall_o, wb_ack_o, req_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: stall/ack/valid=%b expected 000",
               {wb_stall_o, wb_ack_o, req_valid_o});
    end
    checks++;
    if (wb_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_dat: wb_dat_o=%h expected 0", wb_dat_o);
    end
    rst_n = 1'b1;
  endtask

  // Push issued in the same cycle reset is released must land on the next edge.
  task automatic test_single_read();
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 9'h105; wb_sel_i = 4'hF;
    step();
    wb_stb_i = 1'b0;
    checks++;
    if (!(req_valid_o === 1'b1 && req_ramsel_o === 1'b1 && req_adr_o === 8'h05 &&
          req_we_o === 1'b0 && wb_ack_o === 1'b0)) begin
      errors++;
      $display("FAIL read_head: valid=%b ramsel=%b adr=%h we=%b ack=%b expected 1 1 05 0 0",
               req_valid_o, req_ramsel_o, req_adr_o, req_we_o, wb_ack_o);
    end
    grant_i = 1'b1;
    step();
    grant_i = 1'b0; ram_rdata_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (!(wb_ack_o === 1'b1 && wb_dat_o === 32'hDEADBEEF && req_valid_o === 1'b0)) begin
      errors++;
      $display("FAIL read_ack: ack=%b dat=%h valid=%b expected 1 deadbeef 0",
               wb_ack_o, wb_dat_o, req_valid_o);
    end
    step();
    checks++;
    if (!(wb_ack_o === 1'b0 && wb_dat_o === 32'h0)) begin
      errors++; $display("FAIL read_ack_end: ack=%b dat=%h expected 0 0", wb_ack_o, wb_dat_o);
    end
  endtask

  task automatic test_back_pressure();
    wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 9'h011; wb_dat_i = 32'hA1; grant_i = 1'b0;
    step();
    checks++;
    if (wb_stall_o !== 1'b0) begin
      errors++; $display("FAIL bp_stall1: stall=%b expected 0", wb_stall_o);
    end
    wb_adr_i = 9'h122; wb_dat_i = 32'hA2;
    step();
    wb_adr_i = 9'h033; wb_dat_i = 32'hA3;
    checks++;
    if (wb_stall_o !== 1'b1) begin
      errors++; $display("FAIL bp_stall2: stall=%b expected 1", wb_stall_o);
    end
    step();
    checks++;
    if (!(wb_stall_o === 1'b1 && req_adr_o === 8'h11 && req_dat_o === 32'hA1 &&
          wb_ack_o === 1'b0)) begin
      errors++;
      $display("FAIL bp_hold: stall=%b adr=%h dat=%h ack=%b expected 1 11 a1 0",
               wb_stall_o, req_adr_o, req_dat_o, wb_ack_o);
    end
    grant_i = 1'b1;
    step();
    grant_i = 1'b0;
    checks++;
    if (!(wb_stall_o === 1'b0 && wb_ack_o === 1'b1 && wb_dat_o === 32'h0 &&
          req_adr_o === 8'h22 && req_ramsel_o === 1'b1)) begin
      errors++;
      $display("FAIL bp_grant: stall=%b ack=%b dat=%h adr=%h sel=%b expected 0 1 0 22 1",
               wb_stall_o, wb_ack_o, wb_dat_o, req_adr_o, req_ramsel_o);
    end
    step();
    wb_stb_i = 1'b0;
    checks++;
    if (!(wb_stall_o === 1'b1 && wb_ack_o === 1'b0 && req_adr_o === 8'h22)) begin
      errors++;
      $display("FAIL bp_third_in: stall=%b ack=%b adr=%h expected 1 0 22",
               wb_stall_o, wb_ack_o, req_adr_o);
    end
    grant_i = 1'b1;
    step();
    checks++;
    if (!(wb_ack_o === 1'b1 && req_adr_o === 8'h33 && req_dat_o === 32'hA3 &&
          req_ramsel_o === 1'b0)) begin
      errors++;
      $display("FAIL bp_drain1: ack=%b adr=%h dat=%h sel=%b expected 1 33 a3 0",
               wb_ack_o, req_adr_o, req_dat_o, req_ramsel_o);
    end
    step();
    grant_i = 1'b0;
    checks++;
    if (!(wb_ack_o === 1'b1 && req_valid_o === 1'b0)) begin
      errors++;
      $display("FAIL bp_drain2: ack=%b valid=%b expected 1 0", wb_ack_o, req_valid_o);
    end
    step();
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL bp_idle: ack=%b expected 0", wb_ack_o);
    end
  endtask

  task automatic test_streaming();
    int mcount = 0;
    int pop_idx = 0;
    int acks = 0;
    logic mvalid, mpop;
    wb_we_i = 1'b0; grant_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wb_stb_i = (i < 8);
      wb_adr_i = 9'(i);
      #1;
      mvalid = (mcount != 0);
      mpop   = mvalid;
      checks++;
      if (req_valid_o !== mvalid || (mvalid && req_adr_o !== 8'(pop_idx))) begin
        errors++;
        $display("FAIL stream_head[%0d]: valid=%b adr=%h expected %b %h",
                 i, req_valid_o, req_adr_o, mvalid, 8'(pop_idx));
      end
      if (mpop) pop_idx++;
      mcount = mcount + ((i < 8) ? 1 : 0) - (mpop ? 1 : 0);
      step();
      if (wb_ack_o === 1'b1) acks++;
      checks++;
      if (wb_ack_o !== mpop || wb_stall_o !== 1'b0) begin
        errors++;
        $display("FAIL stream_ack[%0d]: ack=%b stall=%b expected %b 0",
                 i, wb_ack_o, wb_stall_o, mpop);
      end
    end
    grant_i = 1'b0; wb_stb_i = 1'b0;
    checks++;
    if (acks != 8) begin
      errors++; $display("FAIL stream_count: acks=%0d expected 8", acks);
    end
  endtask

  task automatic test_abort();
    wb_we_i = 1'b0; wb_stb_i = 1'b1; grant_i = 1'b0; wb_adr_i = 9'h044;
    step(); step();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    #1;
    checks++;
    if (!(req_valid_o === 1'b0 && wb_ack_o === 1'b0)) begin
      errors++;
      $display("FAIL abort_drop: valid=%b ack=%b expected 0 0", req_valid_o, wb_ack_o);
    end
    step();
    wb_cyc_i = 1'b1;
    #1;
    checks++;
    if (!(req_valid_o === 1'b0 && wb_stall_o === 1'b0 && wb_ack_o === 1'b0)) begin
      errors++;
      $display("FAIL abort_flush: valid=%b stall=%b ack=%b expected 0 0 0",
               req_valid_o, wb_stall_o, wb_ack_o);
    end
    wb_stb_i = 1'b1; wb_adr_i = 9'h0AB;
    step();
    wb_stb_i = 1'b0; grant_i = 1'b1;
    step();
    grant_i = 1'b0; ram_rdata_i = 32'h0BAD_F00D;
    #1;
    checks++;
    if (!(wb_ack_o === 1'b1 && wb_dat_o === 32'h0BAD_F00D)) begin
      errors++;
      $display("FAIL abort_resume: ack=%b dat=%h expected 1 0badf00d", wb_ack_o, wb_dat_o);
    end
    // Pop then drop cyc in the ack cycle: the ack must never be seen.
    wb_stb_i = 1'b1; wb_adr_i = 9'h001;
    step();
    wb_stb_i = 1'b0; grant_i = 1'b1;
    step();
    grant_i = 1'b0; wb_cyc_i = 1'b0;
    #1;
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL abort_ack_mask: ack=%b dat=%h expected 0 0", wb_ack_o, wb_dat_o);
    end
    step();
    wb_cyc_i = 1'b1;
    #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL abort_ack_clear: ack=%b expected 0", wb_ack_o);
    end
  endtask

  task automatic test_async_reset();
    int stray = 0;
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 9'h077; grant_i = 1'b0;
    step(); step();
    wb_stb_i = 1'b0; grant_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_stall_o, wb_ack_o, req_valid_o} !== 3'b000 || wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: stall/ack/valid=%b dat=%h expected 000 0",
               {wb_stall_o, wb_ack_o, req_valid_o}, wb_dat_o);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wb_ack_o !== 1'b0 || req_valid_o !== 1'b0) stray++;
    end
    grant_i = 1'b0;
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL async_no_ack: stray cycles=%0d expected 0", stray);
    end
  endtask

`ifdef WB_PORT_BUFFER_STATS_EN
  task automatic test_stall_counter();
    wb_stb_i = 1'b1; wb_adr_i = 9'h010; grant_i = 1'b0;
    step();
    wb_stb_i = 1'b0;
    repeat (70000) step();
    checks++;
    if (stall_cnt_o !== 16'hFFFF) begin
      errors++; $display("FAIL stats_sat: stall_cnt=%h expected ffff", stall_cnt_o);
    end
    repeat (5) step();
    checks++;
    if (stall_cnt_o !== 16'hFFFF) begin
      errors++; $display("FAIL stats_hold: stall_cnt=%h expected ffff", stall_cnt_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall_cnt_o !== 16'h0) begin
      errors++; $display("FAIL stats_reset: stall_cnt=%h expected 0", stall_cnt_o);
    end
    step();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_back_pressure();
    test_streaming();
    test_abort();
    test_async_reset();
`ifdef WB_PORT_BUFFER_STATS_EN
    test_stall_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_buffer.md
WB_PORT_BUFFER -- requirements
Module: wb_port_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter AW, default 9, SHALL be the Wishbone word-address width.
REQ-003 Parameter DW, default 32, SHALL be the data width.
REQ-004 Port clk, input, 1: the single clock; all state is rising-edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Ports wb_cyc_i, wb_stb_i and wb_we_i, input, 1 each: Wishbone pipelined cycle, strobe and write-enable.
REQ-007 Ports wb_adr_i (AW), wb_dat_i (DW) and wb_sel_i (DW/8), input: address, write data and byte selects.
REQ-008 Ports wb_stall_o and wb_ack_o, output, 1 each: stall and acknowledge to the master.
REQ-009 Port wb_dat_o, output, DW: read data to the master.
REQ-010 Port req_valid_o, output, 1: the head request is presented to the collision arbiter.
REQ-011 Port req_ramsel_o, output, 1: the RAM bank wanted by the head request, equal to head adr[AW-1].
REQ-012 Ports req_adr_o (AW-1), req_we_o (1), req_dat_o (DW) and req_sel_o (DW/8), output: the head request fields, with the address bank-local.
REQ-013 Port grant_i, input, 1: the arbiter accepted the head request this cycle.
REQ-014 Port ram_rdata_i, input, DW: the selected bank's synchronous read data, valid one cycle after grant.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of requests {adr, we, dat, sel} with a count of 0..2.
REQ-016 Push SHALL occur when wb_cyc_i && wb_stb_i && !wb_stall_o.
REQ-017 wb_stall_o SHALL equal (count==2), driven from registered count only.
REQ-018 req_valid_o SHALL equal (count!=0) && wb_cyc_i; all req_* fields SHALL come from the head entry.
REQ-019 Pop SHALL occur when req_valid_o && grant_i.
REQ-020 On simultaneous push and pop, count SHALL be unchanged and ordering preserved.
REQ-021 grant_i while req_valid_o is low SHALL be ignored.
REQ-022 Without a grant, the head SHALL stay stable with req_valid_o high (retry every cycle); there SHALL be no timeout.
REQ-023 A pop in cycle N SHALL assert wb_ack_o for exactly cycle N+1, in request order; ack latency SHALL be at least 1.
REQ-024 wb_dat_o SHALL equal ram_rdata_i while wb_ack_o is high for a read, and SHALL be 0 otherwise.
REQ-025 If wb_cyc_i is low at a clock edge, the block SHALL flush the FIFO (count=0) and clear any pending ack for the next cycle.
REQ-026 wb_ack_o SHALL never assert while wb_cyc_i is low.
REQ-027 Each pushed request SHALL produce exactly one ack unless flushed; there SHALL be no ack without a push.

Reset
REQ-028 Asserting rst_n low SHALL immediately set count=0, wb_ack_o=0, wb_stall_o=0, req_valid_o=0, wb_dat_o=0 and the ack pipeline to 0, with FIFO data don't-care.
REQ-029 Reset asserted mid-transaction SHALL discard all pending requests without emitting acks.
REQ-030 Deassertion SHALL be synchronous to clk; the first push SHALL be accepted on the first edge after release.

Configuration
REQ-031 With macro WB_PORT_BUFFER_STATS_EN defined, the block SHALL add output stall_cnt_o (16 bits).
REQ-032 When enabled, stall_cnt_o SHALL increment each cycle req_valid_o && !grant_i, saturate at 16'hFFFF, and reset to 0.
REQ-033 Without WB_PORT_BUFFER_STATS_EN, the port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-034 Single read: push adr=9'h105, grant the next cycle, ram_rdata_i=32'hDEADBEEF -> req_ramsel_o=1, req_adr_o=8'h05, ack one cycle after grant, wb_dat_o=32'hDEADBEEF.
REQ-035 Back-pressure: push 3 back-to-back with grant_i=0 -> stall high after the 2nd push, 3rd held by the master; one grant -> stall drops, 3rd accepted.
REQ-036 Streaming: push every cycle with grant every cycle -> count stays 1, 8 requests yield 8 in-order acks, stall never high.
REQ-037 Abort: count=2, drop wb_cyc_i for 1 cycle -> count=0, no acks, req_valid_o=0; the next cycle runs normally.
REQ-038 Async reset: assert rst_n low between edges with count=2 -> all outputs 0 before the next edge, no acks after release.
REQ-039 STATS_EN: withhold grant for 70000 cycles -> stall_cnt_o=16'hFFFF and holds; reset -> 0.
